// File: rtl/vive_pkg.sv
// -----------------------------------------------------------------------------
// vive_pkg
//   Shared definitions for the triad frame merging path.
//   FRAME_W      : width of one sensor_iterations frame
//   triad_id_w() : width of a triad index for a given number of triads
//   arb_state_e  : arbiter FSM states
// -----------------------------------------------------------------------------
package vive_pkg;

    localparam int FRAME_W = 102;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CAPTURE  = 2'd1,
        ST_ACK_WAIT = 2'd2
    } arb_state_e;

    // Width of a triad index; never narrower than one bit.
    function automatic int triad_id_w(input int num_triads);
        return (num_triads <= 2) ? 1 : $clog2(num_triads);
    endfunction

endpackage

// File: rtl/frame_fifo.sv
// -----------------------------------------------------------------------------
// frame_fifo
//   Synchronous single-clock FIFO holding {triad index, frame} entries.
//   The storage array carries no reset so it can map onto block RAM; only the
//   pointers and the occupancy count are reset.
// Ports
//   clk_i  : clock
//   rst_i  : asynchronous active-high reset (empties the FIFO)
//   push   : write din this cycle (ignored while full)
//   pop    : drop the head entry this cycle (ignored while empty)
//   din    : entry to write
//   dout   : current head entry
//   full   : DEPTH entries held
//   empty  : no entries held
// -----------------------------------------------------------------------------
module frame_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];

    // Push and pop in the same cycle leave the count unchanged.
    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/triad_frame_arbiter.sv
// -----------------------------------------------------------------------------
// triad_frame_arbiter
//   Merges frames from NUM_TRIADS triad_manager instances into one stream for
//   the serial transmitter. Each triad holds data_avl high with a stable frame
//   until acknowledged through reset_parser (4-phase handshake). Requests are
//   served round-robin, queued with their triad index in a small FIFO and
//   handed to the UART, which consumes the head with a rising edge on uart_ack.
//   Everything runs on clk_12MHz; data_avl is synchronised on entry.
// Ports
//   clk_12MHz         : clock (UART domain)
//   reset             : asynchronous active-high reset
//   data_avl          : per-triad frame-valid levels (foreign clock origin)
//   sensor_iterations : packed frames, triad i at [i*FRAME_W +: FRAME_W]
//   reset_parser      : per-triad acknowledge levels, at most one high
//   data_availible    : FIFO head valid
//   frame_out         : FIFO head frame
//   triad_id          : source triad of the FIFO head
//   uart_ack          : UART consumed the head (rising edge pops)
//   overflow_seen     : sticky, a request was held off by a full FIFO
// -----------------------------------------------------------------------------
module triad_frame_arbiter
    import vive_pkg::*;
#(
    parameter int  NUM_TRIADS = 4,
    parameter int  FRAME_W    = vive_pkg::FRAME_W,
    parameter int  FIFO_DEPTH = 4,
    localparam int ID_W       = triad_id_w(NUM_TRIADS)
) (
    input  logic                          clk_12MHz,
    input  logic                          reset,
    input  logic [NUM_TRIADS-1:0]         data_avl,
    input  logic [NUM_TRIADS*FRAME_W-1:0] sensor_iterations,
    output logic [NUM_TRIADS-1:0]         reset_parser,
    output logic                          data_availible,
    output logic [FRAME_W-1:0]            frame_out,
    output logic [ID_W-1:0]               triad_id,
    input  logic                          uart_ack,
    output logic                          overflow_seen
);

    localparam int ENTRY_W = ID_W + FRAME_W;

    // ---------------------------------------------------------------- sync
    logic [NUM_TRIADS-1:0] avl_meta_q;
    logic [NUM_TRIADS-1:0] avl_sync_q;

    always_ff @(posedge clk_12MHz or posedge reset) begin
        if (reset) begin
            avl_meta_q <= '0;
            avl_sync_q <= '0;
        end else begin
            avl_meta_q <= data_avl;
            avl_sync_q <= avl_meta_q;
        end
    end

    // Frame slots; a slot is only sampled while its synced data_avl is high,
    // when the source guarantees it is stable.
    logic [FRAME_W-1:0] frame_slot [NUM_TRIADS];

    generate
        for (genvar gi = 0; gi < NUM_TRIADS; gi++) begin : g_slot
            assign frame_slot[gi] = sensor_iterations[gi*FRAME_W +: FRAME_W];
        end
    endgenerate

    // ---------------------------------------------------------- arbitration
    arb_state_e            state_q;
    logic [ID_W-1:0]       grant_q;
    logic [ID_W-1:0]       rr_q;
    logic [FRAME_W-1:0]    cap_frame_q;
    logic [NUM_TRIADS-1:0] reset_parser_q;
    logic                  overflow_q;

    logic                  req_any;
    logic [ID_W-1:0]       req_idx;
    logic [ID_W-1:0]       rr_next;
    logic [ID_W-1:0]       cand_idx;
    int                    cand;

    logic                  fifo_push;
    logic                  fifo_pop;
    logic [ENTRY_W-1:0]    fifo_din;
    logic [ENTRY_W-1:0]    fifo_dout;
    logic                  fifo_full;
    logic                  fifo_empty;

    // First requester at or above rr_q, wrapping. Scanning from the far end
    // down lets the nearest candidate overwrite the others.
    always_comb begin
        req_any  = 1'b0;
        req_idx  = '0;
        cand     = 0;
        cand_idx = '0;
        for (int k = NUM_TRIADS - 1; k >= 0; k--) begin
            cand = int'(rr_q) + k;
            if (cand >= NUM_TRIADS) begin
                cand = cand - NUM_TRIADS;
            end
            cand_idx = ID_W'(cand);
            if (avl_sync_q[cand_idx]) begin
                req_any = 1'b1;
                req_idx = cand_idx;
            end
        end
    end

    assign rr_next = (grant_q == ID_W'(NUM_TRIADS - 1)) ? '0 : grant_q + 1'b1;

    // The full check uses the registered FIFO state only: a pop in the same
    // cycle does not free the slot for this evaluation.
    always_ff @(posedge clk_12MHz or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            grant_q        <= '0;
            rr_q           <= '0;
            cap_frame_q    <= '0;
            reset_parser_q <= '0;
            overflow_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_any) begin
                        if (fifo_full) begin
                            overflow_q <= 1'b1;
                        end else begin
                            grant_q        <= req_idx;
                            cap_frame_q    <= frame_slot[req_idx];
                            reset_parser_q <= NUM_TRIADS'(1) << req_idx;
                            state_q        <= ST_CAPTURE;
                        end
                    end
                end
                ST_CAPTURE: begin
                    rr_q    <= rr_next;
                    state_q <= ST_ACK_WAIT;
                end
                ST_ACK_WAIT: begin
                    // Release only once the source has seen the acknowledge
                    // and withdrawn its request.
                    if (!avl_sync_q[grant_q]) begin
                        reset_parser_q <= '0;
                        state_q        <= ST_IDLE;
                    end
                end
                default: begin
                    reset_parser_q <= '0;
                    state_q        <= ST_IDLE;
                end
            endcase
        end
    end

    assign fifo_push = (state_q == ST_CAPTURE);
    assign fifo_din  = {grant_q, cap_frame_q};

    frame_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i (clk_12MHz),
        .rst_i (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // ---------------------------------------------------------- output side
    logic               ack_prev_q;
    logic               dav_q;
    logic [FRAME_W-1:0] frame_out_q;
    logic [ID_W-1:0]    triad_id_q;

    // One pop per uart_ack rising edge, and only for a head the UART can
    // actually see (registered valid high) that still exists.
    assign fifo_pop = uart_ack && !ack_prev_q && dav_q && !fifo_empty;

    always_ff @(posedge clk_12MHz or posedge reset) begin
        if (reset) begin
            ack_prev_q  <= 1'b0;
            dav_q       <= 1'b0;
            frame_out_q <= '0;
            triad_id_q  <= '0;
        end else begin
            ack_prev_q <= uart_ack;
            dav_q      <= !fifo_empty;
            // Hold the last head when empty so the bus never shows
            // unwritten storage.
            if (!fifo_empty) begin
                frame_out_q <= fifo_dout[FRAME_W-1:0];
                triad_id_q  <= fifo_dout[ENTRY_W-1:FRAME_W];
            end
        end
    end

    assign reset_parser   = reset_parser_q;
    assign overflow_seen  = overflow_q;
    assign data_availible = dav_q;
    assign frame_out      = frame_out_q;
    assign triad_id       = triad_id_q;

endmodule

// File: tb/tb_triad_frame_arbiter.sv
module tb_triad_frame_arbiter;

    localparam int N     = 4;
    localparam int FW    = 102;
    localparam int DEPTH = 4;
    localparam int IDW   = 2;
    localparam int EW    = IDW + FW;

    logic              clk_12MHz = 1'b0;
    logic              reset;
    logic [N-1:0]      data_avl;
    logic [N*FW-1:0]   sensor_iterations;
    logic [N-1:0]      reset_parser;
    logic              data_availible;
    logic [FW-1:0]     frame_out;
    logic [IDW-1:0]    triad_id;
    logic              uart_ack;
    logic              overflow_seen;

    always #5 clk_12MHz = ~clk_12MHz;

    triad_frame_arbiter #(
        .NUM_TRIADS (N),
        .FRAME_W    (FW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_12MHz         (clk_12MHz),
        .reset             (reset),
        .data_avl          (data_avl),
        .sensor_iterations (sensor_iterations),
        .reset_parser      (reset_parser),
        .data_availible    (data_availible),
        .frame_out         (frame_out),
        .triad_id          (triad_id),
        .uart_ack          (uart_ack),
        .overflow_seen     (overflow_seen)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: expected UART order of {triad, frame}, and the
    // round-robin start point.
    logic [EW-1:0] exp_q [$];
    logic [FW-1:0] frame_tab [N];
    int            m_rr = 0;
    bit            auto_drop = 1'b0;
    bit            auto_uart = 1'b0;

    task automatic check_value(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FW-1:0] rand_frame();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[FW-1:0];
    endfunction

    // A set of simultaneous requests is served starting at the round-robin
    // pointer, moving upward with wrap; the pointer ends one past the last.
    task automatic expect_round(input logic [N-1:0] s);
        int last;
        last = -1;
        for (int k = 0; k < N; k++) begin
            int i;
            logic [IDW-1:0] ii;
            i  = (m_rr + k) % N;
            ii = IDW'(i);
            if (s[ii]) begin
                exp_q.push_back({ii, frame_tab[ii]});
                last = i;
            end
        end
        if (last >= 0) m_rr = (last + 1) % N;
    endtask

    task automatic drive_request(input logic [N-1:0] s);
        for (int k = 0; k < N; k++) begin
            if (s[k]) sensor_iterations[k*FW +: FW] = frame_tab[k];
        end
        data_avl = data_avl | s;
        expect_round(s);
    endtask

    task automatic take_head(input string tag);
        logic [EW-1:0] e;
        if (exp_q.size() == 0) begin
            check_value({tag, "_extra"}, data_availible, 1'b0);
            return;
        end
        e = exp_q.pop_front();
        check_value({tag, "_id"}, triad_id, e[EW-1:FW]);
        check_value({tag, "_frame"}, frame_out, e[FW-1:0]);
        $display("pop triad=%0d frame=%0h", triad_id, frame_out);
    endtask

    // One clock: sample on the falling edge, then act as triads and UART.
    task automatic tick();
        @(negedge clk_12MHz);
        check_value("rp_onehot", ($countones(reset_parser) <= 1), 1'b1);
        if (auto_drop) begin
            for (int i = 0; i < N; i++) begin
                if (reset_parser[i] && data_avl[i]) data_avl[i] = 1'b0;
            end
        end
        if (auto_uart) begin
            if (uart_ack) begin
                uart_ack = 1'b0;
            end else if (data_availible) begin
                if ($urandom_range(0, 2) == 0) begin
                    take_head("pop");
                    uart_ack = 1'b1;
                end
            end else if ($urandom_range(0, 9) == 0) begin
                uart_ack = 1'b1;
            end
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (!(data_avl == '0 && reset_parser == '0) && n < 100) begin
            tick();
            n++;
        end
        check_value(tag, (data_avl == '0 && reset_parser == '0), 1'b1);
    endtask

    task automatic wait_drain(input int bound);
        int n;
        bit done;
        n = 0;
        auto_drop = 1'b1;
        auto_uart = 1'b1;
        done = 1'b0;
        while (!done && n < bound) begin
            tick();
            n++;
            done = (exp_q.size() == 0) && !data_availible && (data_avl == '0) &&
                   (reset_parser == '0) && !uart_ack;
        end
        check_value("drain_done", done, 1'b1);
        if (!done) begin
            exp_q.delete();
            data_avl = '0;
            uart_ack = 1'b0;
        end
        repeat (8) tick();
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        data_avl  = '0;
        uart_ack  = 1'b0;
        auto_drop = 1'b0;
        auto_uart = 1'b0;
        repeat (2) @(negedge clk_12MHz);
        reset = 1'b0;
        exp_q.delete();
        m_rr = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [N-1:0] s;

        reset             = 1'b1;
        data_avl          = '0;
        sensor_iterations = '0;
        uart_ack          = 1'b0;
        repeat (3) @(negedge clk_12MHz);
        check_value("rst_rp", reset_parser, 4'b0);
        check_value("rst_dav", data_availible, 1'b0);
        check_value("rst_frame", frame_out, 0);
        check_value("rst_id", triad_id, 0);
        check_value("rst_ovf", overflow_seen, 1'b0);
        reset = 1'b0;

        // Single frame from triad 2: latency and handshake hold.
        frame_tab[2] = 102'h2A5;
        drive_request(4'b0100);
        repeat (4) tick();
        check_value("lat4_dav", data_availible, 1'b0);
        tick();
        check_value("lat5_dav", data_availible, 1'b1);
        check_value("lat5_frame", frame_out, 102'h2A5);
        check_value("lat5_id", triad_id, 2);
        check_value("lat5_rp", reset_parser, 4'b0100);
        repeat (6) tick();
        check_value("rp_hold", reset_parser, 4'b0100);
        data_avl[2] = 1'b0;
        n = 0;
        while (reset_parser != '0 && n < 10) begin
            tick();
            n++;
        end
        check_value("rp_release", reset_parser, 4'b0);
        take_head("single");
        uart_ack = 1'b1;
        tick();
        uart_ack = 1'b0;
        tick();
        check_value("dav_fall", data_availible, 1'b0);

        // Round-robin of four, then a fifth request against a full FIFO.
        do_reset();
        for (int k = 0; k < N; k++) frame_tab[k] = rand_frame();
        auto_drop = 1'b1;
        drive_request(4'b1111);
        wait_idle("fill4_done");
        check_value("ovf_clear", overflow_seen, 1'b0);
        frame_tab[0] = rand_frame();
        drive_request(4'b0001);
        repeat (20) tick();
        check_value("full_no_grant", reset_parser, 4'b0);
        check_value("full_req_held", data_avl[0], 1'b1);
        check_value("ovf_set", overflow_seen, 1'b1);
        take_head("full_pop");
        uart_ack = 1'b1;
        tick();
        uart_ack = 1'b0;
        n = 0;
        while (data_avl[0] && n < 30) begin
            tick();
            n++;
        end
        check_value("late_grant", data_avl[0], 1'b0);
        wait_drain(300);
        check_value("ovf_sticky", overflow_seen, 1'b1);

        // Pop on the same cycle as a push: both honoured.
        do_reset();
        for (int k = 0; k < N; k++) frame_tab[k] = rand_frame();
        auto_drop = 1'b1;
        drive_request(4'b0011);
        wait_idle("fill2_done");
        repeat (3) tick();
        drive_request(4'b1000);
        repeat (3) tick();
        check_value("cap_phase_rp", reset_parser, 4'b1000);
        take_head("coll");
        uart_ack = 1'b1;
        tick();
        uart_ack = 1'b0;
        tick();
        wait_drain(300);

        // A held uart_ack pops exactly one entry.
        do_reset();
        for (int k = 0; k < N; k++) frame_tab[k] = rand_frame();
        auto_drop = 1'b1;
        drive_request(4'b0111);
        wait_idle("fill3_done");
        repeat (3) tick();
        check_value("hold_dav", data_availible, 1'b1);
        take_head("hold");
        uart_ack = 1'b1;
        repeat (10) tick();
        uart_ack = 1'b0;
        repeat (2) tick();
        check_value("hold_next_frame", frame_out, exp_q[0][FW-1:0]);
        check_value("hold_next_id", triad_id, exp_q[0][EW-1:FW]);
        wait_drain(300);

        // Asynchronous reset in the acknowledge wait, then re-capture.
        do_reset();
        frame_tab[1] = rand_frame();
        drive_request(4'b0010);
        n = 0;
        while (!reset_parser[1] && n < 20) begin
            tick();
            n++;
        end
        repeat (2) tick();
        check_value("pre_rst_dav", data_availible, 1'b1);
        check_value("pre_rst_rp", reset_parser, 4'b0010);
        #2 reset = 1'b1;
        #1;
        check_value("arst_rp", reset_parser, 4'b0);
        check_value("arst_dav", data_availible, 1'b0);
        check_value("arst_frame", frame_out, 0);
        check_value("arst_id", triad_id, 0);
        check_value("arst_ovf", overflow_seen, 1'b0);
        repeat (2) @(negedge clk_12MHz);
        reset = 1'b0;
        exp_q.delete();
        m_rr = 0;
        expect_round(4'b0010);
        wait_drain(200);

        // Randomised rounds of simultaneous requests.
        for (int r = 0; r < 40; r++) begin
            s = N'($urandom_range(1, (1 << N) - 1));
            for (int k = 0; k < N; k++) begin
                frame_tab[k] = rand_frame();
                if (!s[k]) sensor_iterations[k*FW +: FW] = rand_frame();
            end
            drive_request(s);
            wait_drain(600);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
